// File: rtl/slice_sequencer.sv
// Slicing-machine motion scheduler: per slice it advances the mover, strokes the cutter down and up,
// then settles. Optional homing of the mover after the last slice is enabled with SLICE_SEQ_HOME_EN.
module slice_sequencer #(
    parameter int MOVE_TICK_CYC = 50000,
    parameter int CUT_TICK_CYC  = 250000,
    parameter int CUT_STEPS     = 512,
    parameter int SETTLE_CYC    = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        pause_i,
    input  logic [4:0]  slice_num_i,
    input  logic [15:0] pitch_steps_i,
    output logic [3:0]  move_signal_o,
    output logic [3:0]  cut_signal_o,
    output logic        busy_o,
    output logic        finish_o,
    output logic [4:0]  slice_cnt_o,
    output logic [2:0]  state_o
);

    localparam int MAX_A    = (MOVE_TICK_CYC > CUT_TICK_CYC) ? MOVE_TICK_CYC : CUT_TICK_CYC;
    localparam int MAX_TICK = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
    localparam int TICK_W   = $clog2(MAX_TICK + 1);
    localparam int STEP_W   = 21;

    localparam logic [TICK_W-1:0] MOVE_LAST   = TICK_W'(MOVE_TICK_CYC - 1);
    localparam logic [TICK_W-1:0] CUT_LAST    = TICK_W'(CUT_TICK_CYC - 1);
    localparam logic [TICK_W-1:0] SETTLE_LAST = TICK_W'(SETTLE_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_ZERO   = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
    localparam logic [STEP_W-1:0] STEP_ZERO   = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] CUT_LAST_STEP = STEP_W'(CUT_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MOVE     = 3'd1,
        CUT_DOWN = 3'd2,
        CUT_UP   = 3'd3,
        SETTLE   = 3'd4,
        DONE     = 3'd5,
        PAUSED   = 3'd6
`ifdef SLICE_SEQ_HOME_EN
        , HOME   = 3'd7
`endif
    } state_t;

    state_t            state_q, state_d, saved_q, saved_d, run_state_s;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [4:0]        slice_num_q, slice_num_d, slice_cnt_q, slice_cnt_d;
    logic [15:0]       pitch_q, pitch_d;
    logic [1:0]        move_idx_q, move_idx_d, cut_idx_q, cut_idx_d;
    logic [3:0]        move_sig_q, move_sig_d, cut_sig_q, cut_sig_d;
    logic              busy_q, busy_d, finish_q, finish_d;
    logic              pausable_s, move_active_s, cut_active_s;
    logic [STEP_W-1:0] pitch_last_s;
`ifdef SLICE_SEQ_HOME_EN
    logic [STEP_W-1:0] acc_q, acc_d;
`endif

    function automatic logic [3:0] phase_of(input logic [1:0] idx);
        case (idx)
            2'd0:    phase_of = 4'b1000;
            2'd1:    phase_of = 4'b0100;
            2'd2:    phase_of = 4'b0010;
            2'd3:    phase_of = 4'b0001;
            default: phase_of = 4'b0000;
        endcase
    endfunction

    assign pitch_last_s = {5'd0, pitch_q} - 21'd1;
`ifdef SLICE_SEQ_HOME_EN
    assign pausable_s = (state_q == MOVE) || (state_q == CUT_DOWN) || (state_q == CUT_UP) ||
                        (state_q == SETTLE) || (state_q == HOME);
`else
    assign pausable_s = (state_q == MOVE) || (state_q == CUT_DOWN) || (state_q == CUT_UP) ||
                        (state_q == SETTLE);
`endif

    // Next-state, counters and phase indices; pause overrides the natural successor.
    always_comb begin
        run_state_s = state_q;
        tick_d      = tick_q;
        step_d      = step_q;
        slice_num_d = slice_num_q;
        pitch_d     = pitch_q;
        slice_cnt_d = slice_cnt_q;
        move_idx_d  = move_idx_q;
        cut_idx_d   = cut_idx_q;
`ifdef SLICE_SEQ_HOME_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    slice_num_d = slice_num_i;
                    pitch_d     = pitch_steps_i;
                    slice_cnt_d = 5'd0;
                    tick_d      = TICK_ZERO;
                    step_d      = STEP_ZERO;
`ifdef SLICE_SEQ_HOME_EN
                    acc_d       = STEP_ZERO;
`endif
                    if (slice_num_i == 5'd0) begin
                        run_state_s = DONE;
                    end else if (pitch_steps_i == 16'd0) begin
                        run_state_s = CUT_DOWN;
                    end else begin
                        run_state_s = MOVE;
                    end
                end else begin
                    run_state_s = IDLE;
                end
            end
            MOVE: begin
                if (tick_q == MOVE_LAST) begin
                    tick_d     = TICK_ZERO;
                    move_idx_d = move_idx_q + 2'd1;
`ifdef SLICE_SEQ_HOME_EN
                    acc_d      = acc_q + 21'd1;
`endif
                    if (step_q == pitch_last_s) begin
                        step_d      = STEP_ZERO;
                        run_state_s = CUT_DOWN;
                    end else begin
                        step_d      = step_q + 21'd1;
                        run_state_s = MOVE;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            CUT_DOWN: begin
                if (tick_q == CUT_LAST) begin
                    tick_d    = TICK_ZERO;
                    cut_idx_d = cut_idx_q + 2'd1;
                    if (step_q == CUT_LAST_STEP) begin
                        step_d      = STEP_ZERO;
                        run_state_s = CUT_UP;
                    end else begin
                        step_d      = step_q + 21'd1;
                        run_state_s = CUT_DOWN;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            CUT_UP: begin
                if (tick_q == CUT_LAST) begin
                    tick_d    = TICK_ZERO;
                    cut_idx_d = cut_idx_q - 2'd1;
                    if (step_q == CUT_LAST_STEP) begin
                        step_d      = STEP_ZERO;
                        run_state_s = SETTLE;
                    end else begin
                        step_d      = step_q + 21'd1;
                        run_state_s = CUT_UP;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            SETTLE: begin
                if (tick_q == SETTLE_LAST) begin
                    tick_d      = TICK_ZERO;
                    step_d      = STEP_ZERO;
                    slice_cnt_d = slice_cnt_q + 5'd1;
                    if (slice_cnt_d == slice_num_q) begin
`ifdef SLICE_SEQ_HOME_EN
                        // Homing is skipped when the mover never left its start position.
                        if (acc_q != STEP_ZERO) begin
                            run_state_s = HOME;
                        end else begin
                            run_state_s = DONE;
                        end
`else
                        run_state_s = DONE;
`endif
                    end else if (pitch_q == 16'd0) begin
                        run_state_s = CUT_DOWN;
                    end else begin
                        run_state_s = MOVE;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
`ifdef SLICE_SEQ_HOME_EN
            HOME: begin
                if (tick_q == MOVE_LAST) begin
                    tick_d     = TICK_ZERO;
                    move_idx_d = move_idx_q - 2'd1;
                    if (step_q == (acc_q - 21'd1)) begin
                        step_d      = STEP_ZERO;
                        run_state_s = DONE;
                    end else begin
                        step_d      = step_q + 21'd1;
                        run_state_s = HOME;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
`endif
            DONE: begin
                run_state_s = IDLE;
            end
            PAUSED: begin
                if (pause_i) begin
                    run_state_s = saved_q;
                end else begin
                    run_state_s = PAUSED;
                end
            end
            default: begin
                run_state_s = IDLE;
                tick_d      = TICK_ZERO;
                step_d      = STEP_ZERO;
            end
        endcase

        // The pause cycle still does its work, so pausing adds exactly the PAUSED cycles.
        if (pause_i && pausable_s) begin
            state_d = PAUSED;
            saved_d = run_state_s;
        end else begin
            state_d = run_state_s;
            saved_d = saved_q;
        end
    end

`ifdef SLICE_SEQ_HOME_EN
    assign move_active_s = (state_d == MOVE) || (state_d == HOME);
`else
    assign move_active_s = (state_d == MOVE);
`endif
    assign cut_active_s = (state_d == CUT_DOWN) || (state_d == CUT_UP);

    // Output staging: buses follow the next state; PAUSED keeps the last phase for holding torque.
    always_comb begin
        if (state_d == PAUSED) begin
            move_sig_d = move_sig_q;
            cut_sig_d  = cut_sig_q;
        end else begin
            move_sig_d = move_active_s ? phase_of(move_idx_d) : 4'b0000;
            cut_sig_d  = cut_active_s ? phase_of(cut_idx_d) : 4'b0000;
        end
        busy_d   = (state_d != IDLE);
        finish_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            saved_q     <= IDLE;
            tick_q      <= TICK_ZERO;
            step_q      <= STEP_ZERO;
            slice_num_q <= 5'd0;
            pitch_q     <= 16'd0;
            slice_cnt_q <= 5'd0;
            move_idx_q  <= 2'd0;
            cut_idx_q   <= 2'd0;
            move_sig_q  <= 4'b0000;
            cut_sig_q   <= 4'b0000;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
`ifdef SLICE_SEQ_HOME_EN
            acc_q       <= STEP_ZERO;
`endif
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            tick_q      <= tick_d;
            step_q      <= step_d;
            slice_num_q <= slice_num_d;
            pitch_q     <= pitch_d;
            slice_cnt_q <= slice_cnt_d;
            move_idx_q  <= move_idx_d;
            cut_idx_q   <= cut_idx_d;
            move_sig_q  <= move_sig_d;
            cut_sig_q   <= cut_sig_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
`ifdef SLICE_SEQ_HOME_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign move_signal_o = move_sig_q;
    assign cut_signal_o  = cut_sig_q;
    assign busy_o        = busy_q;
    assign finish_o      = finish_q;
    assign slice_cnt_o   = slice_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// Bench for slice_sequencer: a segment-based timeline model predicts every output cycle by cycle,
// with pauses spliced into the timeline.
module tb_slice_sequencer;

    localparam int MT = 4;
    localparam int CT = 2;
    localparam int CS = 3;
    localparam int SC = 5;

    logic        clk = 1'b0;
    logic        rst_n, start_i, pause_i;
    logic [4:0]  slice_num_i;
    logic [15:0] pitch_steps_i;
    logic [3:0]  move_signal_o, cut_signal_o;
    logic        busy_o, finish_o;
    logic [4:0]  slice_cnt_o;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    slice_sequencer #(
        .MOVE_TICK_CYC(MT), .CUT_TICK_CYC(CT), .CUT_STEPS(CS), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .pause_i(pause_i),
        .slice_num_i(slice_num_i), .pitch_steps_i(pitch_steps_i),
        .move_signal_o(move_signal_o), .cut_signal_o(cut_signal_o),
        .busy_o(busy_o), .finish_o(finish_o), .slice_cnt_o(slice_cnt_o), .state_o(state_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] mv;
        logic [3:0] ct;
        logic       fin;
        logic [4:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   m_idx, c_idx;
    int   n_cmp, n_bad;
`ifdef SLICE_SEQ_HOME_EN
    localparam bit HOME_ON = 1'b1;
`else
    localparam bit HOME_ON = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] phase(input int idx);
        int r;
        r = ((idx % 4) + 4) % 4;
        return 4'b1000 >> r;
    endfunction

    function automatic exp_t mk(input int st, input logic [3:0] mv, input logic [3:0] ct,
                                input bit fin, input int cnt);
        exp_t e;
        e.st = 3'(st); e.mv = mv; e.ct = ct; e.fin = fin; e.cnt = 5'(cnt);
        return e;
    endfunction

    // Expected timeline of one full sequence starting on the cycle after start is accepted.
    task automatic build(input int n, input int pitch);
        exp_q.delete();
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < pitch * MT; k++) exp_q.push_back(mk(1, phase(m_idx + k / MT), 4'b0, 1'b0, s));
            m_idx += pitch;
            for (int k = 0; k < CS * CT; k++) exp_q.push_back(mk(2, 4'b0, phase(c_idx + k / CT), 1'b0, s));
            c_idx += CS;
            for (int k = 0; k < CS * CT; k++) exp_q.push_back(mk(3, 4'b0, phase(c_idx - k / CT), 1'b0, s));
            c_idx -= CS;
            for (int k = 0; k < SC; k++) exp_q.push_back(mk(4, 4'b0, 4'b0, 1'b0, s));
        end
        if (HOME_ON && n * pitch > 0) begin
            for (int k = 0; k < n * pitch * MT; k++) exp_q.push_back(mk(7, phase(m_idx - k / MT), 4'b0, 1'b0, n));
            m_idx -= n * pitch;
        end
        exp_q.push_back(mk(5, 4'b0, 4'b0, 1'b1, n));
        exp_q.push_back(mk(0, 4'b0, 4'b0, 1'b0, n));
    endtask

    // A pause pulse in cycle p freezes everything for len cycles shown as PAUSED with held buses.
    task automatic splice_pause(input int p, input int len);
        exp_t h;
        h = mk(6, exp_q[p].mv, exp_q[p].ct, 1'b0, int'(exp_q[p + 1].cnt));
        for (int i = 0; i < len; i++) exp_q.insert(p + 1, h);
    endtask

    task automatic compare_cycle(input int c);
        exp_t e;
        e = exp_q[c];
        check_eq($sformatf("state@%0d", c), 32'(state_o), 32'(e.st));
        check_eq($sformatf("move@%0d", c), 32'(move_signal_o), 32'(e.mv));
        check_eq($sformatf("cut@%0d", c), 32'(cut_signal_o), 32'(e.ct));
        check_eq($sformatf("finish@%0d", c), 32'(finish_o), 32'(e.fin));
        check_eq($sformatf("cnt@%0d", c), 32'(slice_cnt_o), 32'(e.cnt));
        check_eq($sformatf("busy@%0d", c), 32'(busy_o), 32'(e.st != 3'd0));
    endtask

    task automatic start_run(input int n, input int pitch, input bit with_pause);
        slice_num_i   = 5'(n);
        pitch_steps_i = 16'(pitch);
        start_i       = 1'b1;
        pause_i       = with_pause;
        @(negedge clk);
        start_i       = 1'b0;
        pause_i       = 1'b0;
        slice_num_i   = 5'($urandom_range(0, 31));
        pitch_steps_i = 16'($urandom_range(0, 65535));
    endtask

    task automatic run_seq(input int n, input int pitch, input int p, input int len,
                           input int xs, input bit with_pause, output int fin_cyc);
        build(n, pitch);
        if (p >= 0) splice_pause(p, len);
        start_run(n, pitch, with_pause);
        fin_cyc = -1;
        for (int c = 0; c < exp_q.size(); c++) begin
            compare_cycle(c);
            if (finish_o === 1'b1 && fin_cyc < 0) fin_cyc = c;
            pause_i = (p >= 0 && (c == p || c == p + len)) ||
                      (exp_q[c].st == 3'd5 && $urandom_range(0, 1) == 1);
            start_i = (c == xs);
            if (c == xs) slice_num_i = 5'($urandom_range(1, 31));
            @(negedge clk);
        end
        start_i = 1'b0;
        pause_i = 1'b0;
    endtask

    initial begin
        int fin, n, pitch, p, len, xs, home_extra;
        n_cmp = 0; n_bad = 0; m_idx = 0; c_idx = 0;
        home_extra = HOME_ON ? 40 : 0;
        rst_n = 1'b0; start_i = 1'b0; pause_i = 1'b0;
        slice_num_i = 5'd0; pitch_steps_i = 16'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(state_o), 32'd0);
        check_eq("rst_move", 32'(move_signal_o), 32'd0);
        check_eq("rst_cut", 32'(cut_signal_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_finish", 32'(finish_o), 32'd0);
        check_eq("rst_cnt", 32'(slice_cnt_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(2, 5, -1, 0, -1, 1'b0, fin);
        check_eq("finish_cyc_basic", 32'(fin), 32'(74 + home_extra));
        run_seq(0, 7, -1, 0, -1, 1'b1, fin);
        check_eq("finish_cyc_zero", 32'(fin), 32'd0);
        run_seq(2, 5, 10, 12, -1, 1'b0, fin);
        check_eq("finish_cyc_pause", 32'(fin), 32'(86 + home_extra));
        run_seq(1, 0, -1, 0, 3, 1'b0, fin);
        check_eq("finish_cyc_nopitch", 32'(fin), 32'd17);

        // Reset pulse during the second slice's cut-down stroke.
        build(2, 1);
        start_run(2, 1, 1'b0);
        for (int c = 0; c < 27; c++) begin
            compare_cycle(c);
            @(negedge clk);
        end
        check_eq("pre_rst_state", 32'(state_o), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_idx = 0; c_idx = 0;
        check_eq("mid_rst_state", 32'(state_o), 32'd0);
        check_eq("mid_rst_move", 32'(move_signal_o), 32'd0);
        check_eq("mid_rst_cut", 32'(cut_signal_o), 32'd0);
        check_eq("mid_rst_cnt", 32'(slice_cnt_o), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            n     = $urandom_range(0, 3);
            pitch = $urandom_range(0, 4);
            build(n, pitch);
            m_idx -= n * pitch * (HOME_ON ? 0 : 1);
            c_idx = c_idx;
            p = -1;
            len = $urandom_range(1, 8);
            if (exp_q.size() > 3) begin
                p = $urandom_range(0, exp_q.size() - 3);
                if (!(exp_q[p].st inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd7}) || exp_q[p + 1].st == 3'd5) p = -1;
            end
            xs = (exp_q.size() > 2) ? $urandom_range(0, exp_q.size() - 2) : -1;
            if (!HOME_ON) m_idx += n * pitch;
            else m_idx = m_idx;
            if (n * pitch == 0 || HOME_ON) m_idx = m_idx;
            // Rewind the model positions consumed by the probe build, then run for real.
            m_idx -= (HOME_ON ? 0 : n * pitch);
            run_seq(n, pitch, p, len, xs, 1'($urandom_range(0, 1)), fin);
            check_eq($sformatf("finish_seen_r%0d", r), 32'(fin >= 0), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
